// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Bit-serial add/subtract controller. A single full-adder slice is
//   sequenced over WIDTH-bit operands, one bit per clock, LSB first.
//   Subtraction is done as a + ~b + 1: the operand B is inverted at
//   capture and the carry flip-flop is preset to 1.
//
// Ports
//   i_clk    rising-edge clock
//   i_rst_n  synchronous reset, active-low
//   i_start  operation request, sampled only while idle
//   i_sub    0 = a+b, 1 = a-b, sampled with i_start
//   i_a/i_b  WIDTH-bit operands, sampled with i_start
//   o_busy   high while the slice is being sequenced
//   o_done   one-cycle pulse, result outputs freshly published
//   o_sum    result, held until the next completed operation
//   o_cout   final carry out (subtract: 1 = no borrow)
//   o_ovf    signed overflow (carry into MSB ^ carry out of MSB)

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Full-adder slice helpers
  function automatic logic fa_sum(input logic x, input logic y, input logic c);
    return x ^ y ^ c;
  endfunction

  function automatic logic fa_carry(input logic x, input logic y, input logic c);
    return (x & y) | (x & c) | (y & c);
  endfunction

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_slice_sum;
  logic             w_slice_carry;
  logic [WIDTH-1:0] w_acc_next;

  assign w_slice_sum   = fa_sum(r_opa[0], r_opb[0], r_carry);
  assign w_slice_carry = fa_carry(r_opa[0], r_opb[0], r_carry);
  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at bit 0.
  assign w_acc_next    = {w_slice_sum, r_acc[WIDTH-1:1]};

  // Controller FSM, datapath shift registers and registered result outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_opa   <= i_a;
            r_opb   <= i_sub ? ~i_b : i_b;
            r_carry <= i_sub;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_acc   <= w_acc_next;
          r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
          r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
          r_carry <= w_slice_carry;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST_BIT) begin
            // On the MSB slice r_carry is the carry into the MSB, so the
            // overflow flag is formed directly from it here.
            r_sum   <= w_acc_next;
            r_cout  <= w_slice_carry;
            r_ovf   <= r_carry ^ w_slice_carry;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Self-checking bench for serial_adder_ctrl (WIDTH = 8). A cycle-level
//   reference tracks where the current operation is in its timeline and
//   what result it must publish, computed with plain integer arithmetic.
//   Directed scenarios add literal expectations on top.

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_cmp = 0;
  int n_err = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_sub   (sub),
    .i_a     (a),
    .i_b     (b),
    .o_busy  (busy),
    .o_done  (done),
    .o_sum   (sum),
    .o_cout  (cout),
    .o_ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns {ovf, cout, sum} from integer arithmetic on the operands.
  function automatic logic [9:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic s);
    int ux, uy, sx, sy, sr;
    logic [7:0] r;
    logic c, v;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      r  = 8'(ux - uy);
      c  = (ux >= uy);
      sr = sx - sy;
    end else begin
      r  = 8'(ux + uy);
      c  = ((ux + uy) > 255);
      sr = sx + sy;
    end
    v = (sr > 127) || (sr < -128);
    return {v, c, r};
  endfunction

  // Reference timeline: 0 = idle, 1..W = busy cycles, W+1 = done cycle.
  int         m_cycle = 0;
  logic [9:0] m_pend = 10'd0;
  logic [9:0] m_res = 10'd0;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_cycle <= 0;
      m_res   <= 10'd0;
      m_valid <= 1'b1;
    end else if (m_cycle == 0) begin
      if (start) begin
        m_cycle <= 1;
        m_pend  <= ref_op(a, b, sub);
      end
    end else if (m_cycle == W) begin
      m_cycle <= W + 1;
      m_res   <= m_pend;
    end else if (m_cycle == W + 1) begin
      m_cycle <= 0;
    end else begin
      m_cycle <= m_cycle + 1;
    end
  end

  // Every-cycle comparison against the reference
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", 32'(busy), 32'(m_cycle >= 1 && m_cycle <= W));
      check("done", 32'(done), 32'(m_cycle == W + 1));
      check("sum",  32'(sum),  32'(m_res[7:0]));
      check("cout", 32'(cout), 32'(m_res[8]));
      check("ovf",  32'(ovf),  32'(m_res[9]));
    end
  end

  // One operation; optionally pulses start with other operands on RUN cycle inj.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                        input int inj, input logic [9:0] exp, input string tag);
    int cyc;
    int nbusy;
    bit seen;
    @(posedge clk); #1;
    a = ta; b = tb; sub = ts; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 8'hA5; b = 8'h5A; sub = ~ts;
    cyc = 0; nbusy = 0; seen = 1'b0;
    while (!seen && cyc < 30) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        seen = 1'b1;
      end else if (cyc == inj) begin
        start = 1'b1; a = 8'h01; b = 8'h01; sub = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, " done latency"}, seen ? 32'(cyc) : 32'hFFFF_FFFF, 32'(W + 1));
    check({tag, " busy cycles"}, 32'(nbusy), 32'(W));
    check({tag, " sum"},  32'(sum),  32'(exp[7:0]));
    check({tag, " cout"}, 32'(cout), 32'(exp[8]));
    check({tag, " ovf"},  32'(ovf),  32'(exp[9]));
    @(negedge clk);
    check({tag, " done width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int last, ndone, cyc, ndone_rst;

    // Reset
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset sum",  32'(sum),  32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);

    // Pin the reference against hand-computed results
    check("model 35+4A", 32'(ref_op(8'h35, 8'h4A, 1'b0)), 32'h07F);
    check("model FF+01", 32'(ref_op(8'hFF, 8'h01, 1'b0)), 32'h100);
    check("model 7F+01", 32'(ref_op(8'h7F, 8'h01, 1'b0)), 32'h280);
    check("model 10-20", 32'(ref_op(8'h10, 8'h20, 1'b1)), 32'h0F0);
    check("model 80-01", 32'(ref_op(8'h80, 8'h01, 1'b1)), 32'h37F);

    // Basic addition, then a start pulse on RUN cycle 4 that must be ignored
    run_op(8'h35, 8'h4A, 1'b0, 0, 10'h07F, "add 35+4A");
    run_op(8'h35, 8'h4A, 1'b0, 4, 10'h07F, "ignored start");
    repeat (20) begin
      @(negedge clk);
      check("sum hold", 32'(sum), 32'h7F);
    end

    // Boundaries
    run_op(8'hFF, 8'h01, 1'b0, 0, 10'h100, "add FF+01");
    run_op(8'h7F, 8'h01, 1'b0, 0, 10'h280, "add 7F+01");
    run_op(8'h10, 8'h20, 1'b1, 0, 10'h0F0, "sub 10-20");
    run_op(8'h80, 8'h01, 1'b1, 0, 10'h37F, "sub 80-01");

    // Reset during RUN cycle 5 aborts the operation
    @(posedge clk); #1;
    a = 8'hFF; b = 8'h01; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort sum",  32'(sum),  32'd0);
    check("abort cout", 32'(cout), 32'd0);
    check("abort ovf",  32'(ovf),  32'd0);
    ndone_rst = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone_rst++;
    end
    check("abort no done", 32'(ndone_rst), 32'd0);

    // Fresh operation after the abort
    run_op(8'h35, 8'h4A, 1'b0, 0, 10'h07F, "after abort");

    // Back-to-back with start held high and random operands every cycle
    @(posedge clk); #1;
    start = 1'b1;
    a = 8'($urandom_range(255, 0)); b = 8'($urandom_range(255, 0)); sub = 1'($urandom_range(1, 0));
    last = -1; ndone = 0; cyc = 0;
    while (ndone < 256 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (last >= 0) check("b2b gap", 32'(cyc - last), 32'(W + 2));
        last = cyc;
        ndone++;
      end
      @(posedge clk); #1;
      a = 8'($urandom_range(255, 0)); b = 8'($urandom_range(255, 0)); sub = 1'($urandom_range(1, 0));
    end
    check("b2b count", 32'(ndone), 32'd256);
    start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
